// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: per-register in-flight write scoreboard with
// RUN/STALL tracking, pipeline flush, stall statistics and sticky error flags.
module id_hazard_ctrl #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [8:0]        id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic              flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              stalled,
    output logic [4:0]        hazard_reg,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] stall_events,
    output logic              sb_overflow,
    output logic              sb_underflow
);

    typedef enum logic {RUN, STALL} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [PERF_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0]  stall_events_q, stall_events_d;
    logic               sb_overflow_q, sb_overflow_d;
    logic               sb_underflow_q, sb_underflow_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, dest;
    logic       use_rs, use_rt, rs_hit, rt_hit, hazard, stall, issue, dest_valid;
    logic       unused_bits;

    assign opcode      = id_instr[31:26];
    assign rs          = id_instr[25:21];
    assign rt          = id_instr[20:16];
    assign rd          = id_instr[15:11];
    assign unused_bits = ^{id_ctrl[7:6], id_ctrl[4:0], id_instr[10:0]};

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (opcode)
            6'h00, 6'h04, 6'h2B: begin use_rs = 1'b1; use_rt = 1'b1; end
            6'h23, 6'h08:        use_rs = 1'b1;
            default:             ;
        endcase
    end

    always_comb begin
        dest       = id_ctrl[8] ? rd : rt;
        dest_valid = id_ctrl[5] && (dest != 5'd0);
        rs_hit     = use_rs && (rs != 5'd0) && (cnt_q[rs] != '0);
        rt_hit     = use_rt && (rt != 5'd0) && (cnt_q[rt] != '0);
        hazard     = id_valid && (rs_hit || rt_hit);
        stall      = hazard && !flush;
        issue      = id_valid && !stall && !flush;
    end

    // Scoreboard: an increment and decrement on the same register cancel,
    // including the saturated and empty cases, so neither error flag fires then.
    always_comb begin
        logic inc, dec;
        sb_overflow_d  = sb_overflow_q;
        sb_underflow_d = sb_underflow_q;
        for (int unsigned i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            inc = issue && dest_valid && (dest == 5'(i));
            dec = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == 5'(i));
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc && !dec) begin
                if (cnt_q[i] == CNT_W'(MAX_INFLIGHT)) sb_overflow_d = 1'b1;
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) sb_underflow_d = 1'b1;
                else cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        stall_events_d = stall_events_q;
        if (stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        if (stall && (state_q == RUN) && (stall_events_q != '1))
            stall_events_d = stall_events_q + PERF_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall)  state_d = STALL;
            STALL:   if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
            stall_events_q <= '0;
            sb_overflow_q  <= 1'b0;
            sb_underflow_q <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            stall_events_q <= stall_events_d;
            sb_overflow_q  <= sb_overflow_d;
            sb_underflow_q <= sb_underflow_d;
            for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        pc_write     = !stall;
        ifid_write   = !stall;
        idex_bubble  = stall || flush;
        stalled      = (state_q == STALL);
        hazard_reg   = stall ? (rs_hit ? rs : rt) : 5'd0;
        stall_cycles = stall_cycles_q;
        stall_events = stall_events_q;
        sb_overflow  = sb_overflow_q;
        sb_underflow = sb_underflow_q;
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: scoreboard stalls, source decode,
// saturation/error flags, flush and mid-stall reset.
module tb_id_hazard_ctrl;

    localparam logic [8:0] C_R    = 9'b100100010;
    localparam logic [8:0] C_LW   = 9'b011110000;
    localparam logic [8:0] C_ADDI = 9'b010100000;
    localparam logic [8:0] C_SW   = 9'b010001000;
    localparam logic [8:0] C_BEQ  = 9'b000000101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [8:0]  id_ctrl = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_reg = '0;
    logic        flush = 1'b0;
    logic        pc_write, ifid_write, idex_bubble, stalled;
    logic [4:0]  hazard_reg;
    logic [15:0] stall_cycles, stall_events;
    logic        sb_overflow, sb_underflow;

    int total = 0;
    int bad   = 0;

    id_hazard_ctrl #(.CNT_W(2), .MAX_INFLIGHT(3), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .flush(flush), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .stalled(stalled), .hazard_reg(hazard_reg),
        .stall_cycles(stall_cycles), .stall_events(stall_events),
        .sb_overflow(sb_overflow), .sb_underflow(sb_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
        return {op, s, t, 16'h0004};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_instr = '0; id_ctrl = '0;
        wb_reg_write = 1'b0; wb_write_reg = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [8:0] c);
        id_valid = 1'b1; id_instr = ins; id_ctrl = c;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({pc_write, ifid_write, idex_bubble, stalled} !== 4'b1100) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=1100", {pc_write, ifid_write, idex_bubble, stalled}); end
        total++; if (hazard_reg !== 5'd0) begin
            bad++; $display("FAIL reset_hazard_reg got=%0d exp=0", hazard_reg); end
        total++; if ({stall_cycles, stall_events} !== 32'd0) begin
            bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cycles, stall_events); end
        total++; if ({sb_overflow, sb_underflow} !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b exp=00", {sb_overflow, sb_underflow}); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(itype(6'h23, 5'd1, 5'd8), C_LW);
        #1;
        total++; if (pc_write !== 1'b1) begin
            bad++; $display("FAIL lu_lw_issue pc_write got=%b exp=1", pc_write); end
        tick();
        issue(rtype(5'd8, 5'd1, 5'd9), C_R);
        #1;
        total++; if ({pc_write, ifid_write, idex_bubble, hazard_reg} !== {3'b001, 5'd8}) begin
            bad++; $display("FAIL lu_stall got=%b/%0d exp=001/8", {pc_write, ifid_write, idex_bubble}, hazard_reg); end
        tick();
        total++; if (stalled !== 1'b1) begin
            bad++; $display("FAIL lu_stalled got=%b exp=1", stalled); end
        wb_reg_write = 1'b1; wb_write_reg = 5'd8;
        #1;
        total++; if (pc_write !== 1'b0) begin
            bad++; $display("FAIL lu_no_bypass pc_write got=%b exp=0", pc_write); end
        tick();
        wb_reg_write = 1'b0;
        #1;
        total++; if ({pc_write, idex_bubble, hazard_reg} !== {2'b10, 5'd0}) begin
            bad++; $display("FAIL lu_release got=%b/%0d exp=10/0", {pc_write, idex_bubble}, hazard_reg); end
        total++; if ({stall_cycles, stall_events} !== {16'd2, 16'd1}) begin
            bad++; $display("FAIL lu_perf got=%0d/%0d exp=2/1", stall_cycles, stall_events); end
        tick();
        idle();
        #1;
        total++; if (stalled !== 1'b0) begin
            bad++; $display("FAIL lu_back_to_run got=%b exp=0", stalled); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue(rtype(5'd1, 5'd1, 5'd0), C_R);
        tick();
        issue(rtype(5'd0, 5'd0, 5'd2), C_R);
        #1;
        total++; if ({pc_write, hazard_reg} !== {1'b1, 5'd0}) begin
            bad++; $display("FAIL zero_no_stall got=%b/%0d exp=1/0", pc_write, hazard_reg); end
        tick();
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd0;
        tick();
        idle();
        #1;
        total++; if (sb_underflow !== 1'b0) begin
            bad++; $display("FAIL zero_wb_ignored underflow got=%b exp=0", sb_underflow); end
    endtask

    task automatic test_sources();
        do_reset();
        issue(itype(6'h23, 5'd0, 5'd10), C_LW);
        tick();
        issue(itype(6'h23, 5'd0, 5'd11), C_LW);
        tick();
        issue(itype(6'h2B, 5'd11, 5'd10), C_SW);
        #1;
        total++; if (hazard_reg !== 5'd11) begin
            bad++; $display("FAIL src_rs_priority got=%0d exp=11", hazard_reg); end
        issue(itype(6'h04, 5'd0, 5'd10), C_BEQ);
        #1;
        total++; if (hazard_reg !== 5'd10) begin
            bad++; $display("FAIL src_beq_rt got=%0d exp=10", hazard_reg); end
        issue(itype(6'h23, 5'd0, 5'd10), C_LW);
        #1;
        total++; if (pc_write !== 1'b1) begin
            bad++; $display("FAIL src_lw_rt_unused pc_write got=%b exp=1", pc_write); end
        id_valid = 1'b0;
        issue(itype(6'h02, 5'd10, 5'd11), 9'd0);
        #1;
        total++; if (pc_write !== 1'b1) begin
            bad++; $display("FAIL src_jump_no_src pc_write got=%b exp=1", pc_write); end
        issue(rtype(5'd10, 5'd0, 5'd3), C_R);
        id_valid = 1'b0;
        #1;
        total++; if ({pc_write, idex_bubble} !== 2'b10) begin
            bad++; $display("FAIL src_invalid got=%b exp=10", {pc_write, idex_bubble}); end
        id_valid = 1'b1; flush = 1'b1;
        #1;
        total++; if ({pc_write, idex_bubble, hazard_reg} !== {2'b11, 5'd0}) begin
            bad++; $display("FAIL src_flush_over_stall got=%b/%0d exp=11/0", {pc_write, idex_bubble}, hazard_reg); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        issue(itype(6'h08, 5'd0, 5'd5), C_ADDI);
        tick(); tick(); tick();
        total++; if (sb_overflow !== 1'b0) begin
            bad++; $display("FAIL sat_three_ok overflow got=%b exp=0", sb_overflow); end
        tick();
        total++; if (sb_overflow !== 1'b1) begin
            bad++; $display("FAIL sat_overflow got=%b exp=1", sb_overflow); end
        issue(rtype(5'd5, 5'd0, 5'd6), C_R);
        wb_reg_write = 1'b1; wb_write_reg = 5'd5;
        tick();
        total++; if (pc_write !== 1'b0) begin
            bad++; $display("FAIL sat_after_wb1 pc_write got=%b exp=0", pc_write); end
        tick();
        total++; if (pc_write !== 1'b0) begin
            bad++; $display("FAIL sat_after_wb2 pc_write got=%b exp=0", pc_write); end
        tick();
        total++; if ({pc_write, sb_underflow} !== 2'b10) begin
            bad++; $display("FAIL sat_after_wb3 got=%b exp=10", {pc_write, sb_underflow}); end
        id_valid = 1'b0;
        tick();
        total++; if (sb_underflow !== 1'b1) begin
            bad++; $display("FAIL sat_underflow got=%b exp=1", sb_underflow); end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue(itype(6'h08, 5'd0, 5'd7), C_ADDI);
        tick();
        wb_reg_write = 1'b1; wb_write_reg = 5'd7;
        tick();
        wb_reg_write = 1'b0;
        issue(rtype(5'd0, 5'd7, 5'd8), C_R);
        #1;
        total++; if ({pc_write, hazard_reg} !== {1'b0, 5'd7}) begin
            bad++; $display("FAIL same_cycle_net_zero got=%b/%0d exp=0/7", pc_write, hazard_reg); end
        wb_reg_write = 1'b1;
        tick();
        wb_reg_write = 1'b0;
        #1;
        total++; if (pc_write !== 1'b1) begin
            bad++; $display("FAIL same_cycle_release pc_write got=%b exp=1", pc_write); end
        total++; if (sb_underflow !== 1'b0) begin
            bad++; $display("FAIL same_cycle_no_err underflow got=%b exp=0", sb_underflow); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        issue(itype(6'h08, 5'd0, 5'd3), C_ADDI);
        tick();
        issue(rtype(5'd3, 5'd0, 5'd4), C_R);
        tick(); tick(); tick(); tick();
        total++; if (stalled !== 1'b1) begin
            bad++; $display("FAIL flush_pre_stalled got=%b exp=1", stalled); end
        flush = 1'b1;
        #1;
        total++; if ({pc_write, idex_bubble} !== 2'b11) begin
            bad++; $display("FAIL flush_outputs got=%b exp=11", {pc_write, idex_bubble}); end
        tick();
        flush = 1'b0;
        #1;
        total++; if ({stall_cycles, stall_events} !== {16'd4, 16'd1}) begin
            bad++; $display("FAIL flush_perf got=%0d/%0d exp=4/1", stall_cycles, stall_events); end
        total++; if ({stalled, pc_write} !== 2'b01) begin
            bad++; $display("FAIL flush_state got=%b exp=01", {stalled, pc_write}); end
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd3;
        tick();
        total++; if (sb_underflow !== 1'b1) begin
            bad++; $display("FAIL flush_cleared_cnt underflow got=%b exp=1", sb_underflow); end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(itype(6'h08, 5'd0, 5'd3), C_ADDI);
        tick(); tick(); tick(); tick();
        issue(rtype(5'd3, 5'd0, 5'd4), C_R);
        tick(); tick();
        total++; if ({stalled, sb_overflow, stall_cycles} !== {2'b11, 16'd2}) begin
            bad++; $display("FAIL rms_pre got=%b/%0d exp=11/2", {stalled, sb_overflow}, stall_cycles); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if ({stalled, pc_write, hazard_reg} !== {2'b01, 5'd0}) begin
            bad++; $display("FAIL rms_state got=%b/%0d exp=01/0", {stalled, pc_write}, hazard_reg); end
        total++; if ({stall_cycles, stall_events, sb_overflow, sb_underflow} !== 34'd0) begin
            bad++; $display("FAIL rms_counters got=%0d/%0d/%b/%b exp=0/0/0/0", stall_cycles, stall_events, sb_overflow, sb_underflow); end
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd3;
        tick();
        total++; if (sb_underflow !== 1'b1) begin
            bad++; $display("FAIL rms_pending_wb underflow got=%b exp=1", sb_underflow); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_sources();
        test_saturation();
        test_same_cycle();
        test_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
